// File: rtl/cam_pkg.sv
// Shared constants, state encodings and the hit-count helper for the CAM match encoder.
package cam_pkg;
  localparam int N_ENTRIES = 16;
  localparam int ADDR_W    = 4;
  localparam int CNT_W     = 5;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] EMIT = 1'b1;

  // Full CNT_W result so an all-ones vector reports N_ENTRIES rather than wrapping.
  function automatic logic [CNT_W-1:0] popcount(input logic [N_ENTRIES-1:0] v);
    logic [CNT_W-1:0] c;
    c = '0;
    for (int i = 0; i < N_ENTRIES; i++) c = c + CNT_W'(v[i]);
    return c;
  endfunction
endpackage

// File: rtl/cam_prio_enc.sv
// Lowest-index priority encoder; also flags when exactly one bit remains set.
module cam_prio_enc
  import cam_pkg::*;
(
  input  logic [N_ENTRIES-1:0] vec,
  output logic [ADDR_W-1:0]    idx,
  output logic                 one_hot_remaining
);
  always_comb begin
    idx = '0;
    for (int i = N_ENTRIES - 1; i >= 0; i--) begin
      if (vec[i]) idx = ADDR_W'(i);
    end
    one_hot_remaining = (vec != '0) && ((vec & (vec - N_ENTRIES'(1))) == '0);
  end
endmodule

// File: rtl/cam_match_encoder.sv
// Latches one CAM match vector per lookup and streams out its hit indices, lowest first.
module cam_match_encoder
  import cam_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_ENTRIES-1:0] match_vec,
  input  logic                 match_valid,
  output logic                 match_ready,
  output logic [ADDR_W-1:0]    addr_out,
  output logic                 addr_valid,
  input  logic                 addr_ready,
  output logic                 addr_last,
  output logic [CNT_W-1:0]     match_count,
  output logic                 miss
);
  logic [0:0]           state_p0;
  logic [0:0]           state_nxt;
  logic [N_ENTRIES-1:0] pending_p0;
  logic [N_ENTRIES-1:0] pending_nxt;
  logic                 accept;
  logic                 fire;
  logic [ADDR_W-1:0]    enc_idx;
  logic                 enc_last;

  assign match_ready = (state_p0 == IDLE) && !rst;
  assign accept      = match_valid && match_ready;
  assign fire        = addr_valid && addr_ready;

  // Encoding the next pending value lets the address outputs stay registered
  // while still presenting the first hit one cycle after acceptance.
  always_comb begin
    state_nxt   = state_p0;
    pending_nxt = pending_p0;
    if (accept) begin
      pending_nxt = match_vec;
      state_nxt   = (match_vec != '0) ? EMIT : IDLE;
    end else if (fire) begin
      pending_nxt = pending_p0 & (pending_p0 - N_ENTRIES'(1));
      if (addr_last) state_nxt = IDLE;
    end
  end

  cam_prio_enc u_prio_enc (
    .vec               (pending_nxt),
    .idx               (enc_idx),
    .one_hot_remaining (enc_last)
  );

  // Stage p0 -> registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_p0    <= IDLE;
      pending_p0  <= '0;
      addr_out    <= '0;
      addr_valid  <= 1'b0;
      addr_last   <= 1'b0;
      match_count <= '0;
      miss        <= 1'b0;
    end else begin
      state_p0   <= state_nxt;
      pending_p0 <= pending_nxt;
      addr_out   <= enc_idx;
      addr_valid <= (state_nxt == EMIT);
      addr_last  <= enc_last && (state_nxt == EMIT);
      miss       <= accept && (match_vec == '0);
      if (accept) match_count <= popcount(match_vec);
    end
  end
endmodule

// File: tb/tb_cam_match_encoder.sv
// Scoreboard bench for cam_match_encoder: expected hits queued on send, popped on handshake.
module tb_cam_match_encoder;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] match_vec = '0;
  logic        match_valid = 1'b0;
  logic        match_ready;
  logic [3:0]  addr_out;
  logic        addr_valid;
  logic        addr_ready = 1'b0;
  logic        addr_last;
  logic [4:0]  match_count;
  logic        miss;

  typedef struct packed {
    logic [3:0] addr;
    logic       last;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  cam_match_encoder dut (
    .clk         (clk),
    .rst         (rst),
    .match_vec   (match_vec),
    .match_valid (match_valid),
    .match_ready (match_ready),
    .addr_out    (addr_out),
    .addr_valid  (addr_valid),
    .addr_ready  (addr_ready),
    .addr_last   (addr_last),
    .match_count (match_count),
    .miss        (miss)
  );

  always #5 clk = ~clk;

  // Every address handshake must match the head of the scoreboard.
  always @(negedge clk) begin
    if (!rst && addr_valid && addr_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_addr: got addr=%0d last=%0b, required no output", addr_out, addr_last);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (addr_out !== e.addr || addr_last !== e.last) begin
          errors++;
          $display("FAIL addr_stream: got addr=%0d last=%0b, required addr=%0d last=%0b",
                   addr_out, addr_last, e.addr, e.last);
        end
      end
    end
  end

  // Presents one vector, queues its expected hits, returns 1ns after the accepting edge.
  task automatic send(input logic [15:0] vec);
    int hi;
    int k;
    hi = -1;
    for (int i = 0; i < 16; i++) if (vec[i]) hi = i;
    for (k = 0; k < 40 && !match_ready; k++) @(negedge clk);
    checks++;
    if (!match_ready) begin
      errors++;
      $display("FAIL send_timeout: match_ready=%0b, required 1", match_ready);
    end
    for (int i = 0; i < 16; i++) begin
      if (vec[i]) exp_q.push_back('{addr: 4'(i), last: (i == hi)});
    end
    match_vec   = vec;
    match_valid = 1'b1;
    @(posedge clk);
    #1;
    match_valid = 1'b0;
    match_vec   = $urandom();
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checks++;
    if (match_ready !== 1'b1 || addr_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: ready=%0b valid=%0b, required ready=1 valid=0", match_ready, addr_valid);
    end
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    checks++;
    if ({match_ready, addr_valid, addr_last, miss, addr_out, match_count} !== 13'd0) begin
      errors++;
      $display("FAIL reset_values: ready=%0b valid=%0b last=%0b miss=%0b addr=%0d count=%0d, required all 0",
               match_ready, addr_valid, addr_last, miss, addr_out, match_count);
    end
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_single_hit();
    addr_ready = 1'b1;
    send(16'h0100);
    @(negedge clk);
    checks++;
    if (addr_valid !== 1'b1 || addr_out !== 4'd8 || addr_last !== 1'b1 || match_count !== 5'd1 || match_ready !== 1'b0) begin
      errors++;
      $display("FAIL single_hit: valid=%0b addr=%0d last=%0b count=%0d ready=%0b, required 1 8 1 1 0",
               addr_valid, addr_out, addr_last, match_count, match_ready);
    end
    @(negedge clk);
    checks++;
    if (addr_valid !== 1'b0 || match_ready !== 1'b1) begin
      errors++;
      $display("FAIL single_after: valid=%0b ready=%0b, required valid=0 ready=1", addr_valid, match_ready);
    end
  endtask

  task automatic test_multi_stream();
    logic [3:0] want [3];
    want[0] = 4'd0; want[1] = 4'd2; want[2] = 4'd15;
    addr_ready = 1'b1;
    send(16'h8005);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if (addr_valid !== 1'b1 || addr_out !== want[k] || addr_last !== (k == 2) || match_ready !== 1'b0) begin
        errors++;
        $display("FAIL multi_stream[%0d]: valid=%0b addr=%0d last=%0b ready=%0b, required 1 %0d %0b 0",
                 k, addr_valid, addr_out, addr_last, match_ready, want[k], (k == 2));
      end
    end
    checks++;
    if (match_count !== 5'd3) begin
      errors++;
      $display("FAIL multi_count: got %0d, required 3", match_count);
    end
    @(negedge clk);
    checks++;
    if (addr_valid !== 1'b0) begin
      errors++;
      $display("FAIL multi_end: valid=%0b, required 0", addr_valid);
    end
  endtask

  task automatic test_backpressure();
    addr_ready = 1'b0;
    send(16'h0003);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if (addr_valid !== 1'b1 || addr_out !== 4'd0 || addr_last !== 1'b0) begin
        errors++;
        $display("FAIL stall_hold[%0d]: valid=%0b addr=%0d last=%0b, required 1 0 0", k, addr_valid, addr_out, addr_last);
      end
    end
    @(posedge clk);
    #1 addr_ready = 1'b1;
    for (int k = 0; k < 20 && exp_q.size() != 0; k++) @(negedge clk);
    @(negedge clk);
    checks++;
    if (exp_q.size() != 0 || addr_valid !== 1'b0) begin
      errors++;
      $display("FAIL stall_drain: left=%0d valid=%0b, required 0 0", exp_q.size(), addr_valid);
    end
  endtask

  task automatic test_miss_full();
    addr_ready = 1'b1;
    send(16'h0000);
    @(negedge clk);
    checks++;
    if (miss !== 1'b1 || addr_valid !== 1'b0 || match_count !== 5'd0 || match_ready !== 1'b1) begin
      errors++;
      $display("FAIL miss_pulse: miss=%0b valid=%0b count=%0d ready=%0b, required 1 0 0 1",
               miss, addr_valid, match_count, match_ready);
    end
    @(negedge clk);
    checks++;
    if (miss !== 1'b0) begin
      errors++;
      $display("FAIL miss_width: miss=%0b, required 0", miss);
    end
    send(16'hFFFF);
    for (int k = 0; k < 40 && exp_q.size() != 0; k++) @(negedge clk);
    @(negedge clk);
    checks++;
    if (exp_q.size() != 0 || match_count !== 5'd16 || addr_valid !== 1'b0) begin
      errors++;
      $display("FAIL full_vec: left=%0d count=%0d valid=%0b, required 0 16 0", exp_q.size(), match_count, addr_valid);
    end
  endtask

  task automatic test_reset_mid_emit();
    addr_ready = 1'b1;
    send(16'hF000);
    @(negedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    checks++;
    if (addr_valid !== 1'b0 || addr_out !== 4'd0 || match_ready !== 1'b0 || match_count !== 5'd0) begin
      errors++;
      $display("FAIL reset_mid: valid=%0b addr=%0d ready=%0b count=%0d, required 0 0 0 0",
               addr_valid, addr_out, match_ready, match_count);
    end
    exp_q.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (addr_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_quiet: valid=%0b, required 0", addr_valid);
    end
    send(16'h0010);
    @(negedge clk);
    checks++;
    if (addr_valid !== 1'b1 || addr_out !== 4'd4 || addr_last !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_next: valid=%0b addr=%0d last=%0b, required 1 4 1", addr_valid, addr_out, addr_last);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_back_to_back();
    addr_ready = 1'b1;
    send(16'h0001);
    send(16'h0042);
    for (int k = 0; k < 20 && exp_q.size() != 0; k++) @(negedge clk);
    @(negedge clk);
    checks++;
    if (exp_q.size() != 0 || match_count !== 5'd2) begin
      errors++;
      $display("FAIL back_to_back: left=%0d count=%0d, required 0 2", exp_q.size(), match_count);
    end
  endtask

  initial begin
    test_reset();
    test_single_hit();
    test_multi_stream();
    test_backpressure();
    test_miss_full();
    test_back_to_back();
    test_reset_mid_emit();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL final_queue: left=%0d, required 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
